// File: rtl/rx_packet_sequencer.sv
// Sequencer for the byte-stream packet deframer and its ping-pong payload RAM:
// accepts whole packets into a free bank, drops when none is free, aborts broken packets.
module rx_packet_sequencer #(
  parameter int unsigned PKT_BYTES = 524,
  parameter int unsigned HDR_BYTES = 124,
  parameter int unsigned AW        = 8,
  parameter int unsigned DRAIN_MAX = 4
) (
  input  logic          clock,
  input  logic          aclr_n,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  input  logic          byte_sop,
  output logic [7:0]    dfr_datain,
  output logic          dfr_ena,
  output logic          dfr_sclr,
  input  logic          dfr_wren,
  output logic          ram_wren,
  output logic [AW:0]   ram_wraddr,
  output logic [1:0]    rd_ready,
  input  logic [1:0]    rd_release,
  output logic          pkt_done,
  output logic          pkt_drop,
  output logic          pkt_err
);

  localparam int unsigned WORDS = (PKT_BYTES - HDR_BYTES) / 2;
  localparam int unsigned BCW   = $clog2(PKT_BYTES + 1);
  localparam int unsigned DCW   = $clog2(DRAIN_MAX + 1);

  localparam logic [BCW-1:0] PKT_LAST   = BCW'(PKT_BYTES - 1);
  localparam logic [AW:0]    WORDS_W    = (AW + 1)'(WORDS);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DROP} state_t;

  state_t         state;
  logic [BCW-1:0] byte_cnt;
  logic [AW:0]    word_cnt;
  logic [DCW-1:0] drain_cnt;
  logic           bank;
  logic           next_bank;
  logic           word_ovf;

  logic sel_ok;
  logic sel_bank;
  logic word_write;

  // Prefer the alternating bank; fall back to the other one only if it is free.
  always_comb begin
    sel_ok   = 1'b1;
    sel_bank = next_bank;
    if (rd_ready[next_bank]) begin
      sel_bank = ~next_bank;
      sel_ok   = ~rd_ready[~next_bank];
    end
  end

  assign word_write = dfr_wren && ((state == RECV) || (state == DRAIN));

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      drain_cnt  <= '0;
      bank       <= 1'b0;
      next_bank  <= 1'b0;
      word_ovf   <= 1'b0;
      dfr_datain <= '0;
      dfr_ena    <= 1'b0;
      dfr_sclr   <= 1'b0;
      ram_wren   <= 1'b0;
      ram_wraddr <= '0;
      rd_ready   <= '0;
      pkt_done   <= 1'b0;
      pkt_drop   <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      dfr_datain <= byte_in;
      dfr_ena    <= 1'b0;
      dfr_sclr   <= 1'b0;
      ram_wren   <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_drop   <= 1'b0;
      pkt_err    <= 1'b0;
      rd_ready   <= rd_ready & ~rd_release;

      if (word_write) begin
        if (word_cnt < WORDS_W) begin
          ram_wren   <= 1'b1;
          ram_wraddr <= {bank, word_cnt[AW-1:0]};
          word_cnt   <= word_cnt + 1'b1;
        end else begin
          word_ovf <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (byte_valid && byte_sop) begin
            byte_cnt <= BCW'(1);
            if (sel_ok) begin
              bank     <= sel_bank;
              word_cnt <= '0;
              word_ovf <= 1'b0;
              dfr_ena  <= 1'b1;
              state    <= RECV;
            end else begin
              pkt_drop <= 1'b1;
              state    <= DROP;
            end
          end
        end
        RECV: begin
          if (byte_valid && !byte_sop) begin
            byte_cnt <= byte_cnt + 1'b1;
            dfr_ena  <= 1'b1;
            if (byte_cnt == PKT_LAST) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end else begin
            pkt_err  <= 1'b1;
            dfr_sclr <= 1'b1;
            state    <= IDLE;
          end
        end
        DRAIN: begin
          if (word_cnt == WORDS_W) begin
            // A strobe arriving on the commit cycle is one word too many.
            if (word_ovf || dfr_wren) begin
              pkt_err  <= 1'b1;
              dfr_sclr <= 1'b1;
            end else begin
              rd_ready[bank] <= 1'b1;
              pkt_done       <= 1'b1;
              next_bank      <= ~bank;
            end
            state <= IDLE;
          end else if (drain_cnt == DRAIN_LAST) begin
            pkt_err  <= 1'b1;
            dfr_sclr <= 1'b1;
            state    <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DROP: begin
          if (byte_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == PKT_LAST) state <= IDLE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_packet_sequencer.sv
// Scoreboard bench for rx_packet_sequencer: packet-level reference model feeds an expectation
// queue; a negedge monitor pops one record per outcome pulse and checks writes on the fly.
module tb_rx_packet_sequencer;

  localparam int unsigned PKT_BYTES = 524;
  localparam int unsigned HDR_BYTES = 124;
  localparam int unsigned AW        = 8;
  localparam int unsigned DRAIN_MAX = 4;
  localparam int unsigned WORDS     = (PKT_BYTES - HDR_BYTES) / 2;

  localparam logic [2:0] C_DONE = 3'b100;
  localparam logic [2:0] C_DROP = 3'b010;
  localparam logic [2:0] C_ERR  = 3'b001;

  logic          clock = 1'b0;
  logic          aclr_n;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_sop;
  logic [7:0]    dfr_datain;
  logic          dfr_ena;
  logic          dfr_sclr;
  logic          dfr_wren;
  logic          ram_wren;
  logic [AW:0]   ram_wraddr;
  logic [1:0]    rd_ready;
  logic [1:0]    rd_release;
  logic          pkt_done;
  logic          pkt_drop;
  logic          pkt_err;

  always #5 clock = ~clock;

  rx_packet_sequencer #(
    .PKT_BYTES(PKT_BYTES),
    .HDR_BYTES(HDR_BYTES),
    .AW       (AW),
    .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clock     (clock),
    .aclr_n    (aclr_n),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_sop  (byte_sop),
    .dfr_datain(dfr_datain),
    .dfr_ena   (dfr_ena),
    .dfr_sclr  (dfr_sclr),
    .dfr_wren  (dfr_wren),
    .ram_wren  (ram_wren),
    .ram_wraddr(ram_wraddr),
    .rd_ready  (rd_ready),
    .rd_release(rd_release),
    .pkt_done  (pkt_done),
    .pkt_drop  (pkt_drop),
    .pkt_err   (pkt_err)
  );

  // Behavioural deframer: one word strobe per completed payload byte pair, one cycle later.
  int unsigned dfr_cnt;
  bit          miss_last_word;
  always @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      dfr_cnt  <= 0;
      dfr_wren <= 1'b0;
    end else if (dfr_sclr) begin
      dfr_cnt  <= 0;
      dfr_wren <= 1'b0;
    end else begin
      dfr_wren <= dfr_ena && (dfr_cnt >= HDR_BYTES) && (((dfr_cnt - HDR_BYTES) % 2) == 1)
                  && !(miss_last_word && ((dfr_cnt - HDR_BYTES) / 2 == WORDS - 1));
      if (dfr_ena) dfr_cnt <= (dfr_cnt == PKT_BYTES - 1) ? 0 : dfr_cnt + 1;
    end
  end

  logic [7:0] last_in;
  always @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) last_in <= '0;
    else         last_in <= byte_in;
  end

  typedef struct {
    logic [2:0]  code;
    logic        bank;
    logic [1:0]  ready;
    int unsigned ena;
    int unsigned sclr;
    int unsigned wmin;
    int unsigned wmax;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  logic [1:0]  m_ready;
  logic        m_nb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_reset();
    check("rst_dfr_datain", 32'(dfr_datain), 32'h0);
    check("rst_dfr_ena",    32'(dfr_ena),    32'h0);
    check("rst_dfr_sclr",   32'(dfr_sclr),   32'h0);
    check("rst_ram_wren",   32'(ram_wren),   32'h0);
    check("rst_ram_wraddr", 32'(ram_wraddr), 32'h0);
    check("rst_rd_ready",   32'(rd_ready),   32'h0);
    check("rst_pulses",     32'({pkt_done, pkt_drop, pkt_err}), 32'h0);
  endtask

  // Monitor: checks every write address against the open packet, and each outcome pulse
  // against the record queued when that packet was issued.
  initial begin
    exp_t        e;
    int unsigned mon_ena, mon_sclr, mon_w;
    mon_ena = 0; mon_sclr = 0; mon_w = 0;
    forever begin
      @(negedge clock);
      if (!aclr_n) begin
        mon_ena = 0; mon_sclr = 0; mon_w = 0;
      end else begin
        if (dfr_ena) check("dfr_datain", 32'(dfr_datain), 32'(last_in));
        mon_ena  += 32'(dfr_ena);
        mon_sclr += 32'(dfr_sclr);
        if (ram_wren) begin
          if (exp_q.size() == 0) check("wren_outside_packet", 32'(ram_wren), 32'h0);
          else begin
            check("ram_wraddr", 32'(ram_wraddr), 32'({exp_q[0].bank, mon_w[AW-1:0]}));
            mon_w++;
          end
        end
        if (pkt_done || pkt_drop || pkt_err) begin
          if (exp_q.size() == 0) check("outcome_unexpected", 32'({pkt_done, pkt_drop, pkt_err}), 32'h0);
          else begin
            e = exp_q.pop_front();
            check("outcome_code", 32'({pkt_done, pkt_drop, pkt_err}), 32'(e.code));
            check("rd_ready_at_outcome", 32'(rd_ready), 32'(e.ready));
            check("dfr_ena_cycles", mon_ena, e.ena);
            check("dfr_sclr_pulses", mon_sclr, e.sclr);
            n_cmp++;
            if (mon_w < e.wmin || mon_w > e.wmax) begin
              n_mis++;
              $display("FAIL word_count: got %0d, expected %0d..%0d (t=%0t)", mon_w, e.wmin, e.wmax, $time);
            end
          end
          mon_ena = 0; mon_sclr = 0; mon_w = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic release_banks(input logic [1:0] m);
    rd_release = m;
    tick();
    rd_release = '0;
    m_ready = m_ready & ~m;
    @(negedge clock);
    check("rd_ready_after_release", 32'(rd_ready), 32'(m_ready));
    tick();
  endtask

  // len: contiguous bytes sent; sop_pos: position of a stray sop (0 = none);
  // rel: release pulse coincident with the sop; rst_at: assert reset after this byte (0 = none).
  task automatic send_pkt(input int unsigned len, input int unsigned sop_pos, input bit miss,
                          input logic [1:0] rel, input bit pattern, input int unsigned rst_at);
    exp_t        e;
    logic        ok;
    logic        sel;
    int unsigned n;
    ok = 1'b1;
    sel = m_nb;
    if (m_ready[m_nb]) begin
      sel = ~m_nb;
      ok  = ~m_ready[~m_nb];
    end
    m_ready = m_ready & ~rel;
    e.bank = sel; e.ena = 0; e.sclr = 0; e.wmin = 0; e.wmax = 0;
    if (!ok) e.code = C_DROP;
    else if (sop_pos != 0 || len < PKT_BYTES) begin
      n = (sop_pos != 0) ? sop_pos - 1 : len;
      e.code = C_ERR; e.ena = n; e.sclr = 1;
      e.wmin = (n > HDR_BYTES) ? (n - 1 - HDR_BYTES) / 2 : 0;
      e.wmax = (n > HDR_BYTES) ? (n - HDR_BYTES) / 2 : 0;
    end else if (miss) begin
      e.code = C_ERR; e.ena = PKT_BYTES; e.sclr = 1; e.wmin = WORDS - 1; e.wmax = WORDS - 1;
    end else begin
      e.code = C_DONE; e.ena = PKT_BYTES; e.wmin = WORDS; e.wmax = WORDS;
      m_ready[sel] = 1'b1;
      m_nb = ~sel;
    end
    e.ready = m_ready;
    exp_q.push_back(e);
    miss_last_word = miss;

    for (int unsigned i = 1; i <= len; i++) begin
      byte_valid = 1'b1;
      byte_sop   = (i == 1) || (i == sop_pos);
      byte_in    = pattern ? ((i > HDR_BYTES) ? 8'((i - HDR_BYTES - 1) % 144) : 8'(i)) : 8'($urandom);
      rd_release = (i == 1) ? rel : 2'b00;
      tick();
      if (i == sop_pos) break;
      if (i == rst_at) begin
        #2 aclr_n = 1'b0;
        #1 check_reset();
        exp_q.delete();
        m_ready = '0;
        m_nb    = 1'b0;
        break;
      end
    end
    byte_valid = 1'b0;
    byte_sop   = 1'b0;
    rd_release = '0;
    if (rst_at != 0) begin
      tick();
      aclr_n = 1'b1;
    end
    repeat (8 + $urandom_range(0, 6)) tick();
  endtask

  initial begin
    int unsigned len, sp;
    aclr_n = 1'b0; byte_in = '0; byte_valid = 1'b0; byte_sop = 1'b0; rd_release = '0;
    miss_last_word = 1'b0; m_ready = '0; m_nb = 1'b0;
    repeat (3) @(posedge clock);
    #1 check_reset();
    aclr_n = 1'b1;
    tick();

    send_pkt(PKT_BYTES, 0, 0, 2'b00, 1, 0);   // bank 0
    send_pkt(PKT_BYTES, 0, 0, 2'b00, 0, 0);   // bank 1
    send_pkt(PKT_BYTES, 0, 0, 2'b00, 0, 0);   // drop
    release_banks(2'b01);
    send_pkt(PKT_BYTES, 0, 0, 2'b00, 0, 0);   // bank 0 again

    release_banks(2'b11);
    send_pkt(300, 0, 0, 2'b00, 0, 0);         // gap abort
    send_pkt(PKT_BYTES, 0, 0, 2'b00, 0, 0);
    send_pkt(PKT_BYTES, 200, 0, 2'b00, 0, 0); // stray sop abort
    send_pkt(PKT_BYTES, 0, 0, 2'b00, 0, 0);

    release_banks(2'b11);
    send_pkt(PKT_BYTES, 0, 0, 2'b00, 0, 400); // reset mid-packet

    release_banks(2'b10);                      // non-ready bank: no change
    send_pkt(PKT_BYTES, 0, 0, 2'b00, 0, 0);
    release_banks(2'b10);
    send_pkt(PKT_BYTES, 0, 0, 2'b00, 0, 0);
    send_pkt(PKT_BYTES, 0, 0, 2'b01, 0, 0);   // drop: selection ignores same-cycle release
    send_pkt(PKT_BYTES, 0, 0, 2'b00, 0, 0);

    release_banks(2'b11);
    send_pkt(PKT_BYTES, 0, 1, 2'b00, 0, 0);   // missing final word -> drain timeout
    send_pkt(1, 0, 0, 2'b00, 0, 0);           // single-byte packet

    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) release_banks(2'($urandom));
      case ($urandom_range(0, 3))
        0: begin len = $urandom_range(2, PKT_BYTES - 1); sp = 0; end
        1: begin len = PKT_BYTES; sp = $urandom_range(2, PKT_BYTES); end
        default: begin len = PKT_BYTES; sp = 0; end
      endcase
      send_pkt(len, sp, 0, 2'($urandom), 0, 0);
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
